// File: rtl/pe_pkt_pkg.sv
// ============================================================================
// Module : pe_pkt_pkg
// Brief  : PE packet format shared by the packetizer, the depacketizer and benches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pe_pkt_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int WIDTH      = DATA_WIDTH + 4;
  localparam int TS_BIT     = WIDTH - 1;
  localparam int SEL_BIT    = WIDTH - 2;
  localparam int ROW_HI     = WIDTH - 3;
  localparam int ROW_LO     = DATA_WIDTH;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_WIDTH  = 16;

  typedef struct packed {
    logic                  ts;
    logic                  sel;
    logic [1:0]            row;
    logic [DATA_WIDTH-1:0] data;
  } pe_packet_t;

endpackage

`default_nettype wire

// File: rtl/packetizer_if.sv
// ============================================================================
// Module : packetizer_if
// Brief  : Field input channels and NoC-facing output channel of the packetizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface packetizer_if #(
  parameter int DATA_WIDTH = pe_pkt_pkg::DATA_WIDTH,
  parameter int WIDTH      = DATA_WIDTH + 4
);
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            data_valid;
  logic                            data_ready;
  logic [1:0]                      row_in;
  logic                            row_valid;
  logic                            row_ready;
  logic                            sel_in;
  logic                            sel_valid;
  logic                            sel_ready;
  logic                            ts_in;
  logic                            ts_valid;
  logic                            ts_ready;
  logic [WIDTH-1:0]                out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [pe_pkt_pkg::CNT_WIDTH-1:0] pkt_cnt;

  modport master (
    output data_in, data_valid, row_in, row_valid, sel_in, sel_valid,
           ts_in, ts_valid, out_ready,
    input  data_ready, row_ready, sel_ready, ts_ready, out_data, out_valid, pkt_cnt
  );

  modport slave (
    input  data_in, data_valid, row_in, row_valid, sel_in, sel_valid,
           ts_in, ts_valid, out_ready,
    output data_ready, row_ready, sel_ready, ts_ready, out_data, out_valid, pkt_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pkt_fifo.sv
// ============================================================================
// Module : pkt_fifo
// Brief  : Small synchronous FIFO; the read port holds the last popped word when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pkt_fifo #(
  parameter int WIDTH      = 28,
  parameter int FIFO_DEPTH = 2,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count < CW'(FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Stale slots are never exposed; an empty FIFO shows the word most recently popped.
  assign rdata = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/packetizer.sv
// ============================================================================
// Module : packetizer
// Brief  : Collects ts/sel/row/data fields into PE packets and queues them for the NoC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module packetizer #(
  parameter int WIDTH      = pe_pkt_pkg::WIDTH,
  parameter int DATA_WIDTH = pe_pkt_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = pe_pkt_pkg::FIFO_DEPTH
) (
  input logic         clk,
  input logic         rst,
  packetizer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0]            r_data;
  logic [1:0]                       r_row;
  logic                             r_sel;
  logic                             r_ts;
  logic                             r_data_cap;
  logic                             r_row_cap;
  logic                             r_sel_cap;
  logic                             r_ts_cap;
  logic [pe_pkt_pkg::CNT_WIDTH-1:0] r_pkt_cnt;

  logic                             w_assemble;
  logic                             w_push;
  logic                             w_pop;
  logic [CW-1:0]                    w_count;
  logic [WIDTH-1:0]                 w_packet;
  logic [WIDTH-1:0]                 w_rdata;

  assign w_assemble = r_data_cap && r_row_cap && r_sel_cap && r_ts_cap;
  assign w_pop      = (w_count != '0) && bus.out_ready;
  assign w_push     = w_assemble && ((w_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_packet   = {r_ts, r_sel, r_row, r_data};

  // Readies come from flags only, so out_ready reaches them solely through push.
  assign bus.data_ready = !r_data_cap;
  assign bus.row_ready  = !r_row_cap;
  assign bus.sel_ready  = !r_sel_cap;
  assign bus.ts_ready   = !r_ts_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_row      <= '0;
      r_sel      <= 1'b0;
      r_ts       <= 1'b0;
      r_data_cap <= 1'b0;
      r_row_cap  <= 1'b0;
      r_sel_cap  <= 1'b0;
      r_ts_cap   <= 1'b0;
    end else if (w_push) begin
      r_data_cap <= 1'b0;
      r_row_cap  <= 1'b0;
      r_sel_cap  <= 1'b0;
      r_ts_cap   <= 1'b0;
    end else begin
      if (bus.data_valid && !r_data_cap) begin
        r_data     <= bus.data_in;
        r_data_cap <= 1'b1;
      end
      if (bus.row_valid && !r_row_cap) begin
        r_row     <= bus.row_in;
        r_row_cap <= 1'b1;
      end
      if (bus.sel_valid && !r_sel_cap) begin
        r_sel     <= bus.sel_in;
        r_sel_cap <= 1'b1;
      end
      if (bus.ts_valid && !r_ts_cap) begin
        r_ts     <= bus.ts_in;
        r_ts_cap <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_pop) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  pkt_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_packet),
    .pop   (w_pop),
    .rdata (w_rdata),
    .count (w_count)
  );

  assign bus.out_valid = (w_count != '0);
  assign bus.out_data  = w_rdata;
  assign bus.pkt_cnt   = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_packetizer.sv
// ============================================================================
// Module : tb_packetizer
// Brief  : Randomized self-checking bench for the packetizer against a packet-queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_packetizer;
  import pe_pkt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packetizer_if bus ();

  packetizer #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  pe_packet_t       exp_q[$];
  logic [WIDTH-1:0] obs_q[$];
  int               obs_t[$];
  int               exp_rd  = 0;
  int               obs_rd  = 0;
  logic [15:0]      exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every packet accepted by the sink, with the cycle it left.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      obs_q.push_back(bus.out_data);
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] readies();
    return {bus.data_ready, bus.row_ready, bus.sel_ready, bus.ts_ready};
  endfunction

  task automatic idle_fields();
    bus.data_valid = 1'b0;
    bus.row_valid  = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.ts_valid   = 1'b0;
  endtask

  task automatic send_set(input logic [DATA_WIDTH-1:0] d, input logic [1:0] r,
                          input logic s, input logic t, input int gap_pct);
    bit dd = 0, rd = 0, sd = 0, td = 0;
    pe_packet_t p;
    p.ts = t; p.sel = s; p.row = r; p.data = d;
    exp_q.push_back(p);
    for (int c = 0; c < 100 && !(dd && rd && sd && td); c++) begin
      bus.data_valid = !dd && ($urandom_range(99) >= 32'(gap_pct));
      bus.row_valid  = !rd && ($urandom_range(99) >= 32'(gap_pct));
      bus.sel_valid  = !sd && ($urandom_range(99) >= 32'(gap_pct));
      bus.ts_valid   = !td && ($urandom_range(99) >= 32'(gap_pct));
      bus.data_in    = bus.data_valid ? d : DATA_WIDTH'($urandom);
      bus.row_in     = bus.row_valid  ? r : 2'($urandom);
      bus.sel_in     = bus.sel_valid  ? s : 1'($urandom);
      bus.ts_in      = bus.ts_valid   ? t : 1'($urandom);
      @(negedge clk);
      if (bus.data_valid && bus.data_ready) dd = 1;
      if (bus.row_valid && bus.row_ready)   rd = 1;
      if (bus.sel_valid && bus.sel_ready)   sd = 1;
      if (bus.ts_valid && bus.ts_ready)     td = 1;
      @(posedge clk); #1;
    end
    idle_fields();
    n_tests++;
    if ({dd, rd, sd, td} !== 4'b1111) begin
      n_fail++;
      $display("FAIL send_set_capture: got %b want 1111", {dd, rd, sd, td});
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && obs_q.size() - obs_rd < exp_q.size() - exp_rd; c++) begin
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (readies() !== 4'b1111) begin
      n_fail++; $display("FAIL reset_readies: got %b want 1111", readies());
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    n_tests++;
    if (bus.pkt_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_pkt_cnt: got %h want 0", bus.pkt_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_at_once();
    pe_packet_t p;
    bus.out_ready  = 1'b1;
    bus.data_valid = 1'b1; bus.data_in = 24'hABCDEF;
    bus.row_valid  = 1'b1; bus.row_in  = 2'd2;
    bus.sel_valid  = 1'b1; bus.sel_in  = 1'b1;
    bus.ts_valid   = 1'b1; bus.ts_in   = 1'b1;
    p.ts = 1'b1; p.sel = 1'b1; p.row = 2'd2; p.data = 24'hABCDEF;
    exp_q.push_back(p);
    @(posedge clk); #1;
    idle_fields();
    @(negedge clk);
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b0000_0) begin
      n_fail++; $display("FAIL all_assemble_cycle: got %b want 00000", {readies(), bus.out_valid});
    end
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 28'hEABCDEF) begin
      n_fail++; $display("FAIL all_out: got v=%b d=%h want v=1 d=eabcdef", bus.out_valid, bus.out_data);
    end
    n_tests++;
    if (readies() !== 4'b1111) begin
      n_fail++; $display("FAIL all_ready_after_push: got %b want 1111", readies());
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (bus.pkt_cnt !== exp_cnt || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL all_pkt_cnt: got %h/%b want %h/0", bus.pkt_cnt, bus.out_valid, exp_cnt);
    end
    exp_rd = exp_q.size();
    obs_rd = obs_q.size();
    @(posedge clk); #1;
  endtask

  task automatic test_separate();
    bus.out_ready = 1'b1;
    bus.ts_valid = 1'b1; bus.ts_in = 1'b0;
    @(posedge clk); #1;
    bus.ts_valid = 1'b0;
    n_tests++;
    if (readies() !== 4'b1110) begin
      n_fail++; $display("FAIL sep_after_ts: got %b want 1110", readies());
    end
    bus.row_valid = 1'b1; bus.row_in = 2'd0;
    @(posedge clk); #1;
    bus.row_valid = 1'b0;
    n_tests++;
    if (readies() !== 4'b1010) begin
      n_fail++; $display("FAIL sep_after_row: got %b want 1010", readies());
    end
    bus.data_valid = 1'b1; bus.data_in = 24'h000001;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    n_tests++;
    if (readies() !== 4'b0010) begin
      n_fail++; $display("FAIL sep_after_data: got %b want 0010", readies());
    end
    bus.sel_valid = 1'b1; bus.sel_in = 1'b0;
    @(posedge clk); #1;
    bus.sel_valid = 1'b0;
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b0000_0) begin
      n_fail++; $display("FAIL sep_assemble: got %b want 00000", {readies(), bus.out_valid});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b1111_1 || bus.out_data !== 28'h0000001) begin
      n_fail++; $display("FAIL sep_out: got r/v=%b d=%h want 11111 0000001", {readies(), bus.out_valid}, bus.out_data);
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (obs_q.size() - obs_rd !== 1 || bus.pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL sep_single_packet: got n=%0d cnt=%h want n=1 cnt=%h", obs_q.size() - obs_rd, bus.pkt_cnt, exp_cnt);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    repeat (3) send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b0000_1 || bus.out_data !== exp_q[exp_rd]) begin
      n_fail++; $display("FAIL bp_full: got r/v=%b d=%h want 00001 %h", {readies(), bus.out_valid}, bus.out_data, exp_q[exp_rd]);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b1111_1) begin
      n_fail++; $display("FAIL bp_push_on_pop: got %b want 11111", {readies(), bus.out_valid});
    end
    wait_drain(50);
    n_tests++;
    if (obs_q.size() - obs_rd !== 3) begin
      n_fail++; $display("FAIL bp_count: got %0d want 3", obs_q.size() - obs_rd);
    end
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      n_tests++;
      if (obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++; $display("FAIL bp_order: got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      exp_rd++; obs_rd++; exp_cnt = exp_cnt + 16'd1;
    end
    exp_rd = exp_q.size(); obs_rd = obs_q.size();
    n_tests++;
    if (bus.pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL bp_pkt_cnt: got %h want %h", bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_sustained();
    int base = obs_q.size();
    int max_cnt = 0;
    bus.out_ready = 1'b0;
    repeat (2) send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
    bus.out_ready = 1'b1;
    repeat (8) begin
      send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end
    for (int c = 0; c < 40 && obs_q.size() - base < 10; c++) begin
      @(negedge clk);
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      @(posedge clk); #1;
    end
    n_tests++;
    if (obs_q.size() - base !== 10 || max_cnt > FIFO_DEPTH) begin
      n_fail++; $display("FAIL sus_count: got n=%0d max=%0d want n=10 max<=%0d", obs_q.size() - base, max_cnt, FIFO_DEPTH);
    end
    for (int i = base + 3; i < base + 10 && i < obs_t.size(); i++) begin
      n_tests++;
      if (obs_t[i] - obs_t[i-1] !== 2) begin
        n_fail++; $display("FAIL sus_interval: got %0d want 2 at pkt %0d", obs_t[i] - obs_t[i-1], i - base);
      end
    end
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      n_tests++;
      if (obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++; $display("FAIL sus_data: got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      exp_rd++; obs_rd++; exp_cnt = exp_cnt + 16'd1;
    end
    exp_rd = exp_q.size(); obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
    bus.data_valid = 1'b1; bus.data_in = 24'h123456;
    bus.row_valid  = 1'b1; bus.row_in  = 2'd3;
    @(posedge clk); #1;
    idle_fields();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    exp_rd = exp_q.size(); obs_rd = obs_q.size();
    n_tests++;
    if ({readies(), bus.out_valid} !== 5'b1111_0 || bus.pkt_cnt !== 16'h0 || bus.out_data !== '0) begin
      n_fail++; $display("FAIL rstmid_state: got r/v=%b cnt=%h d=%h want 11110 0 0", {readies(), bus.out_valid}, bus.pkt_cnt, bus.out_data);
    end
    bus.out_ready = 1'b1;
    send_set(24'h5A5A5A, 2'd1, 1'b0, 1'b1, 0);
    wait_drain(30);
    n_tests++;
    if (obs_q.size() - obs_rd !== 1 || obs_q[obs_rd] !== 28'h95A5A5A) begin
      n_fail++; $display("FAIL rstmid_packet: got n=%0d d=%h want n=1 d=95a5a5a", obs_q.size() - obs_rd, obs_q[obs_rd]);
    end
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (bus.pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rstmid_pkt_cnt: got %h want %h", bus.pkt_cnt, exp_cnt);
    end
    exp_rd = exp_q.size(); obs_rd = obs_q.size();
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int n = 0; n < 20; n++)
          send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 40);
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain(100);
    n_tests++;
    if (obs_q.size() - obs_rd !== exp_q.size() - exp_rd) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size() - exp_rd);
    end
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      n_tests++;
      if (obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++; $display("FAIL rand_data: got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      exp_rd++; obs_rd++; exp_cnt = exp_cnt + 16'd1;
    end
    exp_rd = exp_q.size(); obs_rd = obs_q.size();
    n_tests++;
    if (bus.pkt_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rand_pkt_cnt: got %h want %h", bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
    bus.out_ready = 1'b1;
    // Stand-in for 65534 earlier packets, which would take far too many cycles to emit.
    force dut.r_pkt_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_pkt_cnt;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      send_set(DATA_WIDTH'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
      repeat (3) begin
        @(posedge clk); #1;
      end
      n_tests++;
      if (bus.pkt_cnt !== want[n]) begin
        n_fail++; $display("FAIL wrap_pkt_cnt: got %h want %h", bus.pkt_cnt, want[n]);
      end
    end
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      n_tests++;
      if (obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++; $display("FAIL wrap_data: got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      exp_rd++; obs_rd++;
    end
  endtask

  initial begin
    idle_fields();
    bus.data_in   = '0;
    bus.row_in    = '0;
    bus.sel_in    = 1'b0;
    bus.ts_in     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_all_at_once();
    test_separate();
    test_backpressure();
    test_sustained();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
